// File: rtl/snax_tcdm_rr_arbiter.sv
// snax_tcdm_rr_arbiter: round-robin share of one TCDM port with in-order response routing
module snax_tcdm_rr_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned IdxW          = $clog2(NumReq),
    localparam int unsigned PtrW          = $clog2(MaxOutstanding),
    localparam int unsigned CntW          = PtrW + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_q_valid_i,
    output logic [NumReq-1:0]              req_q_ready_o,
    input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0]              req_write_i,
    input  logic [NumReq*DataWidth-1:0]    req_data_i,
    input  logic [NumReq*StrbWidth-1:0]    req_strb_i,
    output logic [NumReq-1:0]              req_p_valid_o,
    output logic [DataWidth-1:0]           req_p_data_o,
    output logic                           tcdm_q_valid_o,
    input  logic                           tcdm_q_ready_i,
    output logic [AddrWidth-1:0]           tcdm_addr_o,
    output logic                           tcdm_write_o,
    output logic [DataWidth-1:0]           tcdm_data_o,
    output logic [StrbWidth-1:0]           tcdm_strb_o,
    input  logic                           tcdm_p_valid_i,
    input  logic [DataWidth-1:0]           tcdm_p_data_i,
    output logic [CntW-1:0]                outstanding_o,
    output logic                           err_o
);
    logic [IdxW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, rr_idx, win, head;
    logic            lock_q, lock_d, err_q, err_d, found, lock_hit;
    logic            full, empty, q_valid, hs, pop;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    always_comb begin
        rr_idx = '0;
        found  = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req_q_valid_i[(int'(ptr_q) + i) % NumReq]) begin
                rr_idx = IdxW'((int'(ptr_q) + i) % NumReq);
                found  = 1'b1;
            end
        end
    end

    // A stalled request keeps its grant so the downstream payload stays stable
    assign lock_hit = lock_q && req_q_valid_i[lock_idx_q];
    assign win      = lock_hit ? lock_idx_q : rr_idx;
    assign full     = cnt_q == CntW'(MaxOutstanding);
    assign empty    = cnt_q == '0;
    assign q_valid  = !rst_i && |req_q_valid_i && !full;
    assign hs       = q_valid && tcdm_q_ready_i;
    assign pop      = !rst_i && tcdm_p_valid_i && !empty;
    assign head     = fifo_q[rptr_q];

    assign tcdm_q_valid_o = q_valid;
    assign req_q_ready_o  = hs ? NumReq'(1) << win : '0;
    assign tcdm_addr_o    = q_valid ? req_addr_i[win*AddrWidth +: AddrWidth] : '0;
    assign tcdm_write_o   = q_valid && req_write_i[win];
    assign tcdm_data_o    = q_valid ? req_data_i[win*DataWidth +: DataWidth] : '0;
    assign tcdm_strb_o    = q_valid ? req_strb_i[win*StrbWidth +: StrbWidth] : '0;
    assign req_p_valid_o  = pop ? NumReq'(1) << head : '0;
    assign req_p_data_o   = (!rst_i && tcdm_p_valid_i) ? tcdm_p_data_i : '0;
    assign outstanding_o  = cnt_q;
    assign err_o          = err_q;

    always_comb begin
        ptr_d      = hs ? ((win == IdxW'(NumReq - 1)) ? '0 : win + IdxW'(1)) : ptr_q;
        wptr_d     = wptr_q + PtrW'(hs);
        rptr_d     = rptr_q + PtrW'(pop);
        cnt_d      = cnt_q + CntW'(hs) - CntW'(pop);
        lock_d     = q_valid && !tcdm_q_ready_i;
        lock_idx_d = win;
        err_d      = err_q || (tcdm_p_valid_i && empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            if (hs) fifo_q[wptr_q] <= win;
        end
    end
endmodule

// File: tb/tb_snax_tcdm_rr_arbiter.sv
// tb_snax_tcdm_rr_arbiter: directed vector table plus reset corner sequences
module tb_snax_tcdm_rr_arbiter;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_q_valid_i, req_q_ready_o, req_p_valid_o;
    logic [127:0] req_addr_i, req_data_i;
    logic [3:0]   req_write_i;
    logic [15:0]  req_strb_i;
    logic [31:0]  req_p_data_o, tcdm_addr_o, tcdm_data_o, tcdm_p_data_i;
    logic         tcdm_q_valid_o, tcdm_q_ready_i, tcdm_write_o, tcdm_p_valid_i, err_o;
    logic [3:0]   tcdm_strb_o;
    logic [2:0]   outstanding_o;
    int           n_chk = 0;
    int           n_fail = 0;

    typedef struct {
        logic [3:0]  v;
        logic        rdy;
        logic        pv;
        logic [31:0] pd;
        logic        qv;
        int          w;
        logic [3:0]  pvo;
        logic [2:0]  out;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    snax_tcdm_rr_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_q_valid_i(req_q_valid_i), .req_q_ready_o(req_q_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .req_data_i(req_data_i), .req_strb_i(req_strb_i),
        .req_p_valid_o(req_p_valid_o), .req_p_data_o(req_p_data_o),
        .tcdm_q_valid_o(tcdm_q_valid_o), .tcdm_q_ready_i(tcdm_q_ready_i),
        .tcdm_addr_o(tcdm_addr_o), .tcdm_write_o(tcdm_write_o),
        .tcdm_data_o(tcdm_data_o), .tcdm_strb_o(tcdm_strb_o),
        .tcdm_p_valid_i(tcdm_p_valid_i), .tcdm_p_data_i(tcdm_p_data_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic rdy, input logic pv, input logic [31:0] pd,
                       input logic qv, input int w, input logic [3:0] pvo, input logic [2:0] out,
                       input logic err);
        vecs.push_back('{v, rdy, pv, pd, qv, w, pvo, out, err});
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic pv, input logic [31:0] pd);
        req_q_valid_i  = v;
        tcdm_q_ready_i = rdy;
        tcdm_p_valid_i = pv;
        tcdm_p_data_i  = pd;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_addr_i[i*32 +: 32] = 32'h100 * (i + 1);
            req_data_i[i*32 +: 32] = 32'hDA7A_0000 + i;
            req_strb_i[i*4 +: 4]   = 4'b0001 << i;
        end
        req_write_i = 4'b0101;
        // fairness with immediate responses
        add(4'hF,1,0,0,     1,0,4'h0,0,0);
        add(4'hF,1,1,'hA0,  1,1,4'h1,1,0);
        add(4'hF,1,1,'hA1,  1,2,4'h2,1,0);
        add(4'hF,1,1,'hA2,  1,3,4'h4,1,0);
        add(4'hF,1,1,'hA3,  1,0,4'h8,1,0);
        add(4'hF,1,1,'hA4,  1,1,4'h1,1,0);
        add(4'h0,1,1,'hA5,  0,0,4'h2,1,0);
        // move ptr to 0, then stall req1 while req0 also asks
        add(4'h8,1,0,0,     1,3,4'h0,0,0);
        add(4'hA,0,1,'hB0,  1,1,4'h8,1,0);
        add(4'hB,0,0,0,     1,1,4'h0,0,0);
        add(4'hB,0,0,0,     1,1,4'h0,0,0);
        add(4'hB,1,0,0,     1,1,4'h0,0,0);
        add(4'h9,1,1,'hB1,  1,3,4'h2,1,0);
        add(4'h0,1,1,'hB2,  0,0,4'h8,1,0);
        // locked requester drops valid
        add(4'h2,0,0,0,     1,1,4'h0,0,0);
        add(4'h1,0,0,0,     1,0,4'h0,0,0);
        add(4'h3,1,0,0,     1,0,4'h0,0,0);
        add(4'h0,1,1,'hC0,  0,0,4'h1,1,0);
        // fill FIFO, stall, single pop frees a slot one cycle later
        add(4'hF,1,0,0,     1,1,4'h0,0,0);
        add(4'hF,1,0,0,     1,2,4'h0,1,0);
        add(4'hF,1,0,0,     1,3,4'h0,2,0);
        add(4'hF,1,0,0,     1,0,4'h0,3,0);
        add(4'hF,1,0,0,     0,0,4'h0,4,0);
        add(4'hF,1,1,'hD0,  0,0,4'h2,4,0);
        add(4'hF,1,0,0,     1,1,4'h0,3,0);
        add(4'hF,1,0,0,     0,0,4'h0,4,0);
        add(4'h0,1,1,'hE0,  0,0,4'h4,4,0);
        add(4'h0,1,1,'hE1,  0,0,4'h8,3,0);
        add(4'h0,1,1,'hE2,  0,0,4'h1,2,0);
        add(4'h0,1,1,'hE3,  0,0,4'h2,1,0);
        // issue req2, req0, req2 then route responses in order
        add(4'h4,1,0,0,     1,2,4'h0,0,0);
        add(4'h1,1,0,0,     1,0,4'h0,1,0);
        add(4'h4,1,0,0,     1,2,4'h0,2,0);
        add(4'h0,1,1,'hA,   0,0,4'h4,3,0);
        add(4'h0,1,1,'hB,   0,0,4'h1,2,0);
        add(4'h0,1,1,'hC,   0,0,4'h4,1,0);
        // response with empty FIFO sets sticky error
        add(4'h0,1,1,'hFF,  0,0,4'h0,0,0);
        add(4'hF,1,0,0,     1,3,4'h0,0,1);
        add(4'h0,1,1,'h11,  0,0,4'h8,1,1);
        add(4'h0,1,0,0,     0,0,4'h0,0,1);

        rst_i = 1'b1;
        drive(4'hF, 1'b1, 1'b0, 0);
        #1;
        chk("rst qv", 32'(tcdm_q_valid_o), 0);
        chk("rst qr", 32'(req_q_ready_o), 0);
        chk("rst addr", tcdm_addr_o, 0);
        chk("rst out", 32'(outstanding_o), 0);
        chk("rst err", 32'(err_o), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int r = 0; r < vecs.size(); r++) begin
            vec_t e = vecs[r];
            logic [31:0] e_addr = e.qv ? 32'h100 * (e.w + 1) : 32'h0;
            drive(e.v, e.rdy, e.pv, e.pd);
            #1;
            chk($sformatf("row%0d qv", r), 32'(tcdm_q_valid_o), 32'(e.qv));
            chk($sformatf("row%0d addr", r), tcdm_addr_o, e_addr);
            chk($sformatf("row%0d data", r), tcdm_data_o, e.qv ? 32'hDA7A_0000 + e.w : 0);
            chk($sformatf("row%0d write", r), 32'(tcdm_write_o), 32'(e.qv && e.w % 2 == 0));
            chk($sformatf("row%0d strb", r), 32'(tcdm_strb_o), e.qv ? 32'(1) << e.w : 0);
            chk($sformatf("row%0d qready", r), 32'(req_q_ready_o), (e.qv && e.rdy) ? 32'(1) << e.w : 0);
            chk($sformatf("row%0d pvalid", r), 32'(req_p_valid_o), 32'(e.pvo));
            chk($sformatf("row%0d pdata", r), req_p_data_o, e.pv ? e.pd : 0);
            chk($sformatf("row%0d outstanding", r), 32'(outstanding_o), 32'(e.out));
            chk($sformatf("row%0d err", r), 32'(err_o), 32'(e.err));
            @(negedge clk_i);
        end

        // three grants, then asynchronous reset between edges
        drive(4'hF, 1'b1, 1'b0, 0);
        #1 chk("pre grant0", tcdm_addr_o, 32'h100);
        repeat (3) @(negedge clk_i);
        drive(4'h0, 1'b1, 1'b0, 0);
        #1 chk("pre out3", 32'(outstanding_o), 3);
        req_q_valid_i = 4'hF;
        #1 rst_i = 1'b1;
        #1;
        chk("async qv", 32'(tcdm_q_valid_o), 0);
        chk("async qr", 32'(req_q_ready_o), 0);
        chk("async addr", tcdm_addr_o, 0);
        chk("async out", 32'(outstanding_o), 0);
        chk("async err", 32'(err_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(4'h0, 1'b1, 1'b0, 0);
        #1 chk("post out", 32'(outstanding_o), 0);
        @(negedge clk_i);
        drive(4'h0, 1'b1, 1'b1, 32'h5);
        #1 chk("stale pvalid", 32'(req_p_valid_o), 0);
        @(negedge clk_i);
        drive(4'hF, 1'b1, 1'b0, 0);
        #1;
        chk("stale err", 32'(err_o), 1);
        chk("stale out", 32'(outstanding_o), 0);
        chk("post addr", tcdm_addr_o, 32'h100);
        chk("post qr", 32'(req_q_ready_o), 1);
        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
